// File: rtl/xorshift_pkg.sv
// Shared constants, FSM state type and reference step function for the
// xorshift stream generator.
package xorshift_pkg;

  // Shift triples (a, b, c) for the two supported state widths
  localparam int XS32_A = 13;
  localparam int XS32_B = 17;
  localparam int XS32_C = 5;
  localparam int XS64_A = 13;
  localparam int XS64_B = 7;
  localparam int XS64_C = 17;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } xs_state_e;

  // One xorshift step on a state held in the low 'width' bits of s.
  // All shifts are logical and truncated to the state width.
  function automatic logic [63:0] xorshift_step(input int width, input logic [63:0] s);
    logic [31:0] t32;
    logic [63:0] t64;
    t32 = s[31:0];
    t64 = s;
    if (width == 32) begin
      t32 = t32 ^ (t32 << XS32_A);
      t32 = t32 ^ (t32 >> XS32_B);
      t32 = t32 ^ (t32 << XS32_C);
      t64 = {32'd0, t32};
    end else begin
      t64 = t64 ^ (t64 << XS64_A);
      t64 = t64 ^ (t64 >> XS64_B);
      t64 = t64 ^ (t64 << XS64_C);
    end
    return t64;
  endfunction

endpackage

// File: rtl/xorshift_step_comb.sv
// Purely combinational single xorshift step for a WIDTH-bit state.
module xorshift_step_comb
  import xorshift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] state_o
);

  // The state is widened to 64 bits for the shared step function and
  // truncated back; the step never moves bits above WIDTH into range.
  always_comb begin
    state_o = WIDTH'(xorshift_step(WIDTH, 64'(state_i)));
  end

endmodule

// File: rtl/xorshift_stream.sv
// Xorshift PRNG with a valid/ready output stream, runtime seed load,
// zero-seed substitution and a warm-up discard after reset or seed load.
module xorshift_stream
  import xorshift_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               OUT_WIDTH = 32,
  parameter logic [WIDTH-1:0] INITVAL   = WIDTH'(32'hebd5a728),
  parameter int               DISCARD   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 seed_valid,
  input  logic [WIDTH-1:0]     seed_data,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 busy
);

  if (WIDTH != 32 && WIDTH != 64) begin : gen_bad_width
    $error("xorshift_stream: WIDTH must be 32 or 64");
  end
  if (OUT_WIDTH < 1 || OUT_WIDTH > WIDTH) begin : gen_bad_out_width
    $error("xorshift_stream: OUT_WIDTH must be in 1..WIDTH");
  end
  if (INITVAL == '0) begin : gen_bad_initval
    $error("xorshift_stream: INITVAL must be nonzero");
  end
  if (DISCARD < 0 || DISCARD > 255) begin : gen_bad_discard
    $error("xorshift_stream: DISCARD must be in 0..255");
  end

  localparam xs_state_e  RESET_STATE = (DISCARD == 0) ? RUN : WARMUP;
  localparam logic [7:0] DISCARD_CNT = 8'(DISCARD);

  xs_state_e        state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] stepValue;

  xorshift_step_comb #(
    .WIDTH (WIDTH)
  ) u_step (
    .state_i (s_q),
    .state_o (stepValue)
  );

  // A zero seed would lock the generator at zero, so it is replaced by INITVAL.
  // Seed load takes priority over both warm-up steps and handshakes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    if (seed_valid) begin
      s_d     = (seed_data == '0) ? INITVAL : seed_data;
      cnt_d   = DISCARD_CNT;
      state_d = (DISCARD == 0) ? RUN : WARMUP;
    end else begin
      case (state_q)
        WARMUP: begin
          s_d   = stepValue;
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            s_d = stepValue;
          end
        end
        default: state_d = RESET_STATE;
      endcase
    end
  end

  // State, discard counter and generator register with async restart from INITVAL
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= DISCARD_CNT;
      s_q     <= INITVAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
    end
  end

  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == WARMUP);
  assign out_data  = s_q[WIDTH-1 -: OUT_WIDTH];

endmodule

// File: tb/tb_xorshift_stream.sv
// Self-checking bench: step-function vector table plus directed stream
// sequences on three generator configurations.
module tb_xorshift_stream;

  logic clk = 1'b0;
  logic resetN;

  logic        seedValidA, readyA, validA, busyA;
  logic [31:0] seedDataA, dataA;
  logic        seedValidB, readyB, validB, busyB;
  logic [31:0] seedDataB, dataB;
  logic        seedValidC, readyC, validC, busyC;
  logic [63:0] seedDataC;
  logic [15:0] dataC;

  logic [31:0] stepIn, stepOut;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] stepIn;
    logic [31:0] expStep;
  } stepVec_t;

  stepVec_t vecs [5];

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  xorshift_stream #(.WIDTH(32), .OUT_WIDTH(32), .DISCARD(0)) dutA (
    .clk(clk), .reset_n(resetN), .seed_valid(seedValidA), .seed_data(seedDataA),
    .out_ready(readyA), .out_valid(validA), .out_data(dataA), .busy(busyA)
  );

  xorshift_stream #(.WIDTH(32), .OUT_WIDTH(32), .DISCARD(2)) dutB (
    .clk(clk), .reset_n(resetN), .seed_valid(seedValidB), .seed_data(seedDataB),
    .out_ready(readyB), .out_valid(validB), .out_data(dataB), .busy(busyB)
  );

  xorshift_stream #(.WIDTH(64), .OUT_WIDTH(16), .DISCARD(0)) dutC (
    .clk(clk), .reset_n(resetN), .seed_valid(seedValidC), .seed_data(seedDataC),
    .out_ready(readyC), .out_valid(validC), .out_data(dataC), .busy(busyC)
  );

  xorshift_step_comb #(.WIDTH(32)) u_stepComb (
    .state_i(stepIn),
    .state_o(stepOut)
  );

  function automatic logic [31:0] ref32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [63:0] ref64(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] value);
    stepIn = value;
    #1;
  endtask

  // Directed test sequence
  initial begin
    logic [31:0] expA;
    logic [63:0] expC;
    logic        pattern [4];
    int          zeroHits;

    resetN     = 1'b0;
    seedValidA = 1'b0; seedDataA = '0; readyA = 1'b0;
    seedValidB = 1'b0; seedDataB = '0; readyB = 1'b0;
    seedValidC = 1'b0; seedDataC = '0; readyC = 1'b0;
    stepIn     = '0;

    vecs[0] = '{32'h0000_0001, 32'h0004_2021};
    vecs[1] = '{32'h0004_2021, 32'h0408_0601};
    vecs[2] = '{32'h0000_0002, 32'h0008_4042};
    vecs[3] = '{32'h8000_0000, 32'h8008_4000};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0003_E01F};

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].stepIn);
      checkOutput($sformatf("step_vec%0d", i), 64'(stepOut), 64'(vecs[i].expStep));
    end

    // Reset values
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_validA", 64'(validA), 64'(1));
    checkOutput("rst_busyA",  64'(busyA),  64'(0));
    checkOutput("rst_dataA",  64'(dataA),  64'h0000_0000_ebd5_a728);
    checkOutput("rst_validB", 64'(validB), 64'(0));
    checkOutput("rst_busyB",  64'(busyB),  64'(1));
    checkOutput("rst_validC", 64'(validC), 64'(1));
    checkOutput("rst_dataC",  64'(dataC),  64'(0));
    resetN = 1'b1;

    // Seed 1 with full throughput, DISCARD=0
    seedValidA = 1'b1; seedDataA = 32'h1; readyA = 1'b1;
    @(negedge clk);
    seedValidA = 1'b0;
    checkOutput("a_word0", 64'(dataA), 64'h1);
    checkOutput("a_valid", 64'(validA), 64'(1));
    @(negedge clk);
    checkOutput("a_word1", 64'(dataA), 64'h0004_2021);
    @(negedge clk);
    checkOutput("a_word2", 64'(dataA), 64'h0408_0601);
    readyA = 1'b0;
    @(negedge clk);
    checkOutput("a_hold", 64'(dataA), 64'h0408_0601);

    // Backpressure: ready pattern 1,0,0,1
    seedValidA = 1'b1; seedDataA = 32'h1;
    @(negedge clk);
    seedValidA = 1'b0;
    expA = 32'h1;
    pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b0; pattern[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("bp_word%0d", i), 64'(dataA), 64'(expA));
      readyA = pattern[i];
      @(negedge clk);
      if (pattern[i]) expA = ref32(expA);
    end
    checkOutput("bp_final", 64'(dataA), 64'h0408_0601);

    // Seed coincident with a handshake: seed wins
    readyA = 1'b1;
    seedValidA = 1'b1; seedDataA = 32'h8000_0000;
    @(negedge clk);
    seedValidA = 1'b0;
    checkOutput("prio_seed", 64'(dataA), 64'h8000_0000);
    @(negedge clk);
    checkOutput("prio_next", 64'(dataA), 64'h8008_4000);

    // Zero seed substitutes INITVAL; long run never hits zero
    seedValidA = 1'b1; seedDataA = 32'h0;
    @(negedge clk);
    seedValidA = 1'b0;
    checkOutput("zero_seed", 64'(dataA), 64'h0000_0000_ebd5_a728);
    expA = 32'hebd5_a728;
    zeroHits = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      expA = ref32(expA);
      if (dataA == 32'h0) zeroHits++;
      checkOutput("long_run", 64'(dataA), 64'(expA));
    end
    checkOutput("never_zero", 64'(zeroHits), 64'(0));
    readyA = 1'b0;

    // Warm-up discard with DISCARD=2
    seedValidB = 1'b1; seedDataB = 32'h1;
    @(negedge clk);
    seedValidB = 1'b0;
    checkOutput("wu_busy1",  64'(busyB),  64'(1));
    checkOutput("wu_valid1", 64'(validB), 64'(0));
    @(negedge clk);
    checkOutput("wu_busy2",  64'(busyB),  64'(1));
    checkOutput("wu_valid2", 64'(validB), 64'(0));
    @(negedge clk);
    checkOutput("wu_valid3", 64'(validB), 64'(1));
    checkOutput("wu_busy3",  64'(busyB),  64'(0));
    checkOutput("wu_first",  64'(dataB),  64'h0408_0601);

    // Reset pulsed mid-warm-up takes effect asynchronously
    seedValidB = 1'b1; seedDataB = 32'h1;
    @(negedge clk);
    seedValidB = 1'b0;
    checkOutput("mr_busy_pre", 64'(busyB), 64'(1));
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("mr_busyB",  64'(busyB),  64'(1));
    checkOutput("mr_validB", 64'(validB), 64'(0));
    checkOutput("mr_dataB",  64'(dataB),  64'h0000_0000_ebd5_a728);
    checkOutput("mr_dataA",  64'(dataA),  64'h0000_0000_ebd5_a728);
    checkOutput("mr_validA", 64'(validA), 64'(1));
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    checkOutput("mr_wu_busy",  64'(busyB),  64'(1));
    checkOutput("mr_wu_valid", 64'(validB), 64'(0));
    @(negedge clk);
    checkOutput("mr_run_valid", 64'(validB), 64'(1));
    checkOutput("mr_run_data",  64'(dataB),  64'(ref32(ref32(32'hebd5_a728))));
    checkOutput("mr_holdA",     64'(dataA),  64'h0000_0000_ebd5_a728);

    // 64-bit state, 16-bit output words
    seedValidC = 1'b1; seedDataC = 64'h1;
    @(negedge clk);
    seedValidC = 1'b0;
    checkOutput("c_word0", 64'(dataC), 64'(0));
    checkOutput("c_valid", 64'(validC), 64'(1));
    expC = 64'h1;
    readyC = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      expC = ref64(expC);
      checkOutput("c_stream", 64'(dataC), 64'(expC[63:48]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xorshift_stream.md
Name: xorshift_stream

Overview:
- Parametrised xorshift PRNG with a valid/ready output stream, runtime seed load, zero-seed protection and a post-seed warm-up discard.
- Supersedes the fixed 32-bit free-running generator.
- Feeds test-pattern generators, LFSR-style scramblers and dither logic.
- Consumers pull one word per handshake.

Parameters:
- WIDTH, 32, state width; only 32 or 64 are legal, anything else is an elaboration error. Shift triples: 32 → (13,17,5); 64 → (13,7,17).
- OUT_WIDTH, 32, output word width; 1..WIDTH. Output is the top OUT_WIDTH bits of the state.
- INITVAL, 'hebd5a728 zero-extended to WIDTH, reset and zero-seed substitute state; must be nonzero (elaboration error otherwise).
- DISCARD, 4, number of generator steps discarded after reset or seed load before the first valid word; 0..255.

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- seed_valid  in  1  load seed_data into state this cycle
- seed_data  in  WIDTH  new seed
- out_ready  in  1  consumer accepts out_data
- out_valid  out  1  out_data holds a valid word
- out_data  out  OUT_WIDTH  state[WIDTH-1 -: OUT_WIDTH]
- busy  out  1  high during warm-up

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, reset_n. All state is in flops on posedge clk or negedge reset_n.
- Step function, with s as state and all shifts logical and truncated to WIDTH:
  - s1 = s ^ (s << a)
  - s2 = s1 ^ (s1 >> b)
  - s3 = s2 ^ (s2 << c)
- FSM has two states, WARMUP and RUN, plus an 8-bit discard counter cnt.
- Reset (reset_n low):
  - s = INITVAL; cnt = DISCARD.
  - state = RUN if DISCARD == 0, else WARMUP.
  - out_valid = (DISCARD == 0); busy = (DISCARD != 0).
- WARMUP: every cycle s <= step(s) and cnt <= cnt - 1. When cnt == 1, the next state is RUN. out_valid = 0 and busy = 1 throughout.
- RUN:
  - out_valid = 1 and busy = 0.
  - If out_valid && out_ready: s <= step(s), so the next word appears the following cycle (one word per cycle at full throughput).
  - If out_ready is low: s, and therefore out_data, are held stable.
- Seed load (seed_valid = 1, any state):
  - s <= (seed_data == 0) ? INITVAL : seed_data; cnt <= DISCARD.
  - state <= (DISCARD == 0) ? RUN : WARMUP.
- Priority: seed load beats both a handshake and a warm-up step in the same cycle. A handshake coincident with seed_valid still counts as consumed; the old word is not repeated.
- Latency after seed or reset: first valid word after DISCARD cycles. With DISCARD = 0, the seed itself is the first word on the next cycle.
- out_data in WARMUP is don't-care; the bench checks it only when out_valid = 1.
- State never becomes zero: nonzero is invariant under step, and a zero seed is substituted.
- Reset asserted mid-warm-up or mid-stream restarts from INITVAL immediately (asynchronously). No handshake completes in a reset cycle.

Decomposition:
- Package xorshift_pkg holds:
  - the shift-triple constants per width (XS32_A/B/C, XS64_A/B/C);
  - the state enum (WARMUP, RUN);
  - a function xorshift_step(width, s).
- One sub-module, xorshift_step_comb (combinational, parametrised by WIDTH), instantiated once. It lets the bench check the step function in isolation.

Test Plan:
- WIDTH=32, OUT_WIDTH=32, DISCARD=0; seed_valid with seed 1, out_ready=1 → out_data sequence 0x00000001, 0x00042021, 0x04080601 on consecutive cycles.
- Same configuration with DISCARD=2, seed 1 → busy high 2 cycles, out_valid low; first valid word is 0x04080601.
- Seed 0 loaded → first word equals INITVAL (0xebd5a728 with DISCARD=0); state never zero over 10k steps.
- Backpressure: seed 1, out_ready toggling 1,0,0,1 → 0x00042021 held stable while ready is low. No words are skipped or duplicated, checked against the reference model.
- Reset and seed priority:
  - reset_n pulsed low mid-warm-up → busy/out_valid take their reset values immediately, warm-up restarts from INITVAL;
  - seed_valid coincident with a handshake → the seed wins and the next word is the seed.
- WIDTH=64, OUT_WIDTH=16, DISCARD=0, seed 1 → first word 0x0000, second word equals bits [63:48] of the model's step64(1). Compare 1000 words against the model.
